// File: rtl/hurricane_ctrl.sv
// hurricane_ctrl: sequences the range hood's hurricane (mode 3) airflow session.
//
// Runs alongside mode_fsm and drives two of its inputs. It grants or revokes
// mode 3 and selects where mode_fsm returns when mode 3 is revoked. It times
// the hurricane run, handles an early-exit countdown started by the menu
// button, and exports the remaining seconds for the display driver.
//
// Configuration macro: HURRICANE_ONESHOT_EN
//   defined   : SPENT holds until power-off, so hurricane is available once per power-on.
//   undefined : SPENT returns to READY once mode 3 is left, so hurricane is reusable.
//
// Ports:
//   clk                    system clock
//   rst                    asynchronous, active-low reset
//   machine_state          hood power on (1) / off (0)
//   mode_state[2:0]        current mode from mode_fsm; 3'b011 is hurricane
//   menu_btn               debounced menu button level (rising edge detected here)
//   hurricane_mode_enabled 1 permits entering or staying in mode 3
//   return_state           while enable is 0: 1 returns to mode 2, 0 to standby
//   remaining_sec[7:0]     seconds left in RUN/EXIT, 0 otherwise
//   hc_state[2:0]          OFF=0, READY=1, RUN=2, EXIT=3, SPENT=4
module hurricane_ctrl #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned RUN_SEC  = 60,
  parameter int unsigned EXIT_SEC = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       machine_state,
  input  logic [2:0] mode_state,
  input  logic       menu_btn,
  output logic       hurricane_mode_enabled,
  output logic       return_state,
  output logic [7:0] remaining_sec,
  output logic [2:0] hc_state
);

  localparam int unsigned PW    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned SEC_W = 8;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_READY = 3'd1,
    S_RUN   = 3'd2,
    S_EXIT  = 3'd3,
    S_SPENT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [SEC_W-1:0] sec_d;
  logic             ret_d;
  logic             hme_d;
  logic             menu_prev;
  logic             menu_edge;
  logic             tick;
  logic             mode_hc;
  logic             last_sec;

  assign menu_edge = menu_btn & ~menu_prev;
  assign tick      = (presc_q == PW'(CLK_FREQ - 1));
  assign mode_hc   = (mode_state == 3'b011);
  assign last_sec  = (remaining_sec == SEC_W'(1));
  assign hc_state  = state_q;

  // State, prescaler, seconds counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q                <= S_OFF;
      presc_q                <= '0;
      remaining_sec          <= '0;
      return_state           <= 1'b0;
      hurricane_mode_enabled <= 1'b0;
      menu_prev              <= 1'b0;
    end else begin
      state_q                <= state_d;
      presc_q                <= presc_d;
      remaining_sec          <= sec_d;
      return_state           <= ret_d;
      hurricane_mode_enabled <= hme_d;
      menu_prev              <= menu_btn;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = remaining_sec;
    ret_d   = return_state;
    hme_d   = 1'b0;

    unique case (state_q)
      S_OFF: begin
        if (machine_state) state_d = S_READY;
      end

      S_READY: begin
        if (mode_hc) begin
          state_d = S_RUN;
          sec_d   = SEC_W'(RUN_SEC);
          presc_d = '0;
          ret_d   = 1'b0;
        end
      end

      S_RUN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick && remaining_sec != '0) sec_d = remaining_sec - SEC_W'(1);
        // Expiry beats a simultaneous menu edge; menu beats leaving mode 3.
        if (tick && last_sec) begin
          state_d = S_SPENT;
          ret_d   = 1'b1;
        end else if (menu_edge) begin
          state_d = S_EXIT;
          sec_d   = SEC_W'(EXIT_SEC);
          presc_d = '0;
        end else if (!mode_hc) begin
          state_d = S_SPENT;
          ret_d   = 1'b0;
        end
      end

      S_EXIT: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick && remaining_sec != '0) sec_d = remaining_sec - SEC_W'(1);
        if ((tick && last_sec) || !mode_hc) begin
          state_d = S_SPENT;
          ret_d   = 1'b0;
        end
      end

      S_SPENT: begin
`ifdef HURRICANE_ONESHOT_EN
        state_d = S_SPENT;
`else
        if (!mode_hc) state_d = S_READY;
`endif
      end

      default: begin
        state_d = S_OFF;
      end
    endcase

    // Power-off overrides everything and clears all session state.
    if (!machine_state) begin
      state_d = S_OFF;
      ret_d   = 1'b0;
    end

    // Counters only live in RUN/EXIT.
    if (state_d != S_RUN && state_d != S_EXIT) begin
      presc_d = '0;
      sec_d   = '0;
    end

    hme_d = (state_d == S_READY) || (state_d == S_RUN) || (state_d == S_EXIT);
  end

endmodule
